// File: rtl/util_axis_byte_packer.sv
// AXI-Stream 8-bit to BUS_WIDTH-byte packer, first byte in lane 0, registered output word.
// Optional per-packet tlast generation when UTIL_AXIS_BYTE_PACKER_TLAST_EN is defined.
module util_axis_byte_packer #(
  parameter int BUS_WIDTH    = 4,
  parameter int PACKET_BEATS = 4
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  localparam int CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int AW = (BUS_WIDTH > 1) ? BUS_WIDTH - 1 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_WIDTH - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0][7:0]     acc_q, acc_d;
  logic [BUS_WIDTH*8-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   final_byte, in_xfer, pkt_last;

  assign final_byte    = (cnt_q == CNT_LAST);
  // Only the word-completing byte has to wait for room in the output register.
  assign s_axis_tready = ~final_byte | ~tvalid_q | m_axis_tready;
  assign in_xfer       = s_axis_tvalid & s_axis_tready;

`ifdef UTIL_AXIS_BYTE_PACKER_TLAST_EN
  localparam int BW = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;
  logic [BW-1:0] beat_q, beat_d;

  assign pkt_last = (beat_q == BW'(PACKET_BEATS - 1));

  always_comb begin
    beat_d = beat_q;
    if (in_xfer && final_byte) beat_d = pkt_last ? '0 : beat_q + BW'(1);
  end

  always_ff @(posedge aclk) begin
    if (arst) beat_q <= '0;
    else      beat_q <= beat_d;
  end
`else
  assign pkt_last = 1'b0;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q & ~m_axis_tready;
    if (in_xfer) begin
      if (final_byte) begin
        for (int k = 0; k < BUS_WIDTH - 1; k++) tdata_d[8*k +: 8] = acc_q[k];
        tdata_d[8*(BUS_WIDTH-1) +: 8] = s_axis_tdata;
        tvalid_d = 1'b1;
        tlast_d  = pkt_last;
        cnt_d    = '0;
      end else begin
        acc_d[cnt_q] = s_axis_tdata;
        cnt_d        = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_util_axis_byte_packer.sv
// Directed vector table plus reset/packet sequences on a 4-byte packer, then a
// randomized handshake scoreboard across BUS_WIDTH 1, 3, 4 and 8.
module tb_util_axis_byte_packer;

`ifdef UTIL_AXIS_BYTE_PACKER_TLAST_EN
  localparam bit TL = 1'b1;
`else
  localparam bit TL = 1'b0;
`endif

  function automatic int rw(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 8;
    endcase
  endfunction

  logic        aclk, arst;
  logic [7:0]  d_sdata;
  logic        d_sval, d_sready, d_mvalid, d_mready, d_mlast;
  logic [31:0] d_mdata;

  logic [3:0]       r_sval, r_sready, r_mvalid, r_mready, r_mlast;
  logic [3:0][7:0]  r_sdata;
  logic [3:0][63:0] r_mdata;

  int pass_cnt, chk_cnt;
  logic sr_seen;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  util_axis_byte_packer #(.BUS_WIDTH(4), .PACKET_BEATS(2)) u_dut (
    .aclk(aclk), .arst(arst),
    .s_axis_tdata(d_sdata), .s_axis_tvalid(d_sval), .s_axis_tready(d_sready),
    .m_axis_tdata(d_mdata), .m_axis_tvalid(d_mvalid), .m_axis_tready(d_mready),
    .m_axis_tlast(d_mlast)
  );

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = rw(g);
    logic [W*8-1:0] md;
    util_axis_byte_packer #(.BUS_WIDTH(W), .PACKET_BEATS(3)) u_r (
      .aclk(aclk), .arst(arst),
      .s_axis_tdata(r_sdata[g]), .s_axis_tvalid(r_sval[g]), .s_axis_tready(r_sready[g]),
      .m_axis_tdata(md), .m_axis_tvalid(r_mvalid[g]), .m_axis_tready(r_mready[g]),
      .m_axis_tlast(r_mlast[g])
    );
    assign r_mdata[g] = 64'(md);
  end

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        mr;
    logic        exp_sr;
    logic        exp_mv;
    logic [31:0] exp_md;
    logic        exp_tl;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic mr,
                              input logic sr, input logic mv, input logic [31:0] md,
                              input logic tl);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.exp_sr = sr; v.exp_mv = mv; v.exp_md = md; v.exp_tl = tl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock: drive at negedge, sample s_axis_tready before the edge, outputs after it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(negedge aclk);
    d_sval = v; d_sdata = d; d_mready = r;
    #1 sr_seen = d_sready;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    arst = 1'b1; d_sval = 1'b0; d_mready = 1'b0;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    arst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [63:0] exp;
    int in_cnt[4], out_cnt[4];
    logic hold[4], held_l[4];
    logic [63:0] held_d[4];
    bit done;

    pass_cnt = 0; chk_cnt = 0;
    arst = 1'b1; d_sval = 1'b0; d_sdata = '0; d_mready = 1'b0;
    r_sval = '0; r_sdata = '0; r_mready = '0;

    tbl[0]  = mk(1, 8'h01, 1, 1, 0, 32'h0,        0);
    tbl[1]  = mk(1, 8'h02, 1, 1, 0, 32'h0,        0);
    tbl[2]  = mk(1, 8'h03, 1, 1, 0, 32'h0,        0);
    tbl[3]  = mk(1, 8'h04, 1, 1, 1, 32'h04030201, 0);
    tbl[4]  = mk(1, 8'h05, 1, 1, 0, 32'h04030201, 0);
    tbl[5]  = mk(1, 8'h06, 1, 1, 0, 32'h04030201, 0);
    tbl[6]  = mk(1, 8'h07, 1, 1, 0, 32'h04030201, 0);
    tbl[7]  = mk(1, 8'h08, 1, 1, 1, 32'h08070605, TL);
    tbl[8]  = mk(1, 8'h11, 0, 1, 1, 32'h08070605, TL);
    tbl[9]  = mk(1, 8'h12, 0, 1, 1, 32'h08070605, TL);
    tbl[10] = mk(1, 8'h13, 0, 1, 1, 32'h08070605, TL);
    tbl[11] = mk(1, 8'h14, 0, 0, 1, 32'h08070605, TL);
    tbl[12] = mk(1, 8'h14, 1, 1, 1, 32'h14131211, 0);
    tbl[13] = mk(0, 8'h00, 1, 1, 0, 32'h14131211, 0);

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", d_mvalid, 0);
    chk("rst_tdata", d_mdata, 0);
    chk("rst_tlast", d_mlast, 0);
    chk("rst_tready", d_sready, 1);
    @(negedge aclk);
    arst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].sv, tbl[i].sd, tbl[i].mr);
      chk($sformatf("vec%0d_s_tready", i), sr_seen, tbl[i].exp_sr);
      chk($sformatf("vec%0d_m_tvalid", i), d_mvalid, tbl[i].exp_mv);
      chk($sformatf("vec%0d_m_tdata", i), d_mdata, tbl[i].exp_md);
      chk($sformatf("vec%0d_m_tlast", i), d_mlast, tbl[i].exp_tl);
    end

    // Reset with a pending word and a partial word in flight.
    for (int i = 0; i < 6; i++) cyc(1, 8'hB0 + 8'(i), 0);
    chk("pre_rst_pending", d_mvalid, 1);
    do_reset();
    #1;
    chk("midrst_tvalid", d_mvalid, 0);
    chk("midrst_tdata", d_mdata, 0);
    chk("midrst_tlast", d_mlast, 0);
    chk("midrst_tready", d_sready, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + 8'(i), 1);
    chk("postrst_tvalid", d_mvalid, 1);
    chk("postrst_word", d_mdata, 32'hA3A2A1A0);
    chk("postrst_tlast", d_mlast, 0);
    for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), 1);
    chk("postrst_word2", d_mdata, 32'hC3C2C1C0);
    chk("postrst_tlast2", d_mlast, TL);

    // 16 bytes back to back: 4 words, tlast on words 2 and 4 when enabled.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(1, 8'h20 + 8'(4*j + k), 1);
        chk($sformatf("pkt_s_tready_%0d_%0d", j, k), sr_seen, 1);
      end
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'h20 + 8'(4*j + k);
      chk($sformatf("pkt_tvalid_%0d", j), d_mvalid, 1);
      chk($sformatf("pkt_word_%0d", j), d_mdata, w);
      chk($sformatf("pkt_tlast_%0d", j), d_mlast, TL & (j % 2 == 1));
    end
    cyc(0, 8'h00, 1);
    chk("pkt_idle_tvalid", d_mvalid, 0);

    // Random handshakes on all widths, incrementing byte stream.
    for (int i = 0; i < 4; i++) begin
      in_cnt[i] = 0; out_cnt[i] = 0; hold[i] = 1'b0; held_l[i] = 1'b0; held_d[i] = '0;
    end
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge aclk);
      for (int i = 0; i < 4; i++) begin
        r_sval[i]   = (in_cnt[i] < 1000) && ($urandom_range(1) == 1);
        r_sdata[i]  = 8'(in_cnt[i]);
        r_mready[i] = ($urandom_range(1) == 1);
      end
      #1;
      done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (hold[i]) begin
          chk($sformatf("rnd%0d_hold_valid", rw(i)), r_mvalid[i], 1);
          chk($sformatf("rnd%0d_hold_data", rw(i)), r_mdata[i], held_d[i]);
          chk($sformatf("rnd%0d_hold_last", rw(i)), r_mlast[i], held_l[i]);
        end
        if (r_sval[i] && r_sready[i]) in_cnt[i]++;
        if (r_mvalid[i] && r_mready[i]) begin
          exp = '0;
          for (int k = 0; k < rw(i); k++) exp[8*k +: 8] = 8'(out_cnt[i] + k);
          chk($sformatf("rnd%0d_word", rw(i)), r_mdata[i], exp);
          out_cnt[i] += rw(i);
        end
        hold[i]   = r_mvalid[i] & ~r_mready[i];
        held_d[i] = r_mdata[i];
        held_l[i] = r_mlast[i];
        if (in_cnt[i] < 1000 || out_cnt[i] < (1000 / rw(i)) * rw(i)) done = 1'b0;
      end
    end
    chk("rnd_timeout", done, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rnd%0d_bytes_out", rw(i)), out_cnt[i], (1000 / rw(i)) * rw(i));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/util_axis_byte_packer.md
# util_axis_byte_packer

AXI-Stream byte packer that gathers consecutive 8-bit beats into one BUS_WIDTH-byte output word, first byte in the least significant lane. Sits directly downstream of util_axis_tiny_fifo, taking its 8-bit m_axis output and widening it for wider datapath consumers (DMA, wide FIFOs). Sustains one input byte per clock while the downstream sink is ready. The output word is registered.

## Interface
- BUS_WIDTH, 4: output width in bytes; legal range 1..8.
- PACKET_BEATS, 4: output words per packet for tlast generation; legal range ≥1. Used only with UTIL_AXIS_BYTE_PACKER_TLAST_EN.

- aclk  in  1  clock; all logic on rising edge.
- arst  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  8  input byte.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  block can accept a byte.
- m_axis_tdata  out  BUS_WIDTH*8  packed word.
- m_axis_tvalid  out  1  packed word valid.
- m_axis_tready  in  1  sink accepts word.
- m_axis_tlast  out  1  last word of packet; constant 0 without the macro.

## Operation
- State: byte counter cnt (0..BUS_WIDTH-1), accumulator acc of (BUS_WIDTH-1) bytes, output register (tdata, tvalid, tlast), beat counter beat (0..PACKET_BEATS-1, macro only).
- Input transfer occurs on s_axis_tvalid & s_axis_tready.
- Transfer with cnt < BUS_WIDTH-1: byte stored in acc lane cnt; cnt increments.
- Transfer with cnt == BUS_WIDTH-1 (the final byte): m_axis_tdata loads {byte, acc[lane BUS_WIDTH-2] … acc[lane 0]}; m_axis_tvalid set; cnt returns to 0. Lane k is bits [8k+7:8k].
- s_axis_tready = (cnt != BUS_WIDTH-1) | ~m_axis_tvalid | m_axis_tready. The accumulator never stalls. Only the final byte waits for the output register.
- Output transfer occurs on m_axis_tvalid & m_axis_tready. It clears m_axis_tvalid unless a final byte is accepted in the same cycle, in which case the new word loads and tvalid stays 1. This is the simultaneous case.
- While m_axis_tvalid=1 & m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- BUS_WIDTH=1: acc unused. The block is a one-deep registered pipeline stage.
- No flush. A partial word stays in acc until completed or reset.
- Byte order and count are preserved exactly. No bytes are dropped or duplicated.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, cnt=0, beat=0, acc=0. After reset, s_axis_tready=1.
- Reset mid-word or mid-packet discards the partial word and any pending output word. The next accepted byte is lane 0 of a new word, and the packet restarts at beat 0.
- Latency: the final byte is accepted at edge N, and m_axis_tvalid=1 after edge N.
- Throughput: with m_axis_tready held 1, one word is produced every BUS_WIDTH cycles of continuous input.
- s_axis_tready has a combinational path from m_axis_tready and registered state only. There is no path from s_axis_tvalid.

## Configuration
- UTIL_AXIS_BYTE_PACKER_TLAST_EN defined: beat counts output words as they are loaded into the output register.
  - The word loaded at beat == PACKET_BEATS-1 carries m_axis_tlast=1, and beat wraps to 0.
  - Every other loaded word carries m_axis_tlast=0.
- Not defined: m_axis_tlast is tied 0 and no beat counter is built.

## Test plan
- Bytes 0x01..0x08 streamed with s_axis_tvalid=1 and m_axis_tready=1 (BUS_WIDTH=4) -> words 0x04030201 then 0x08070605. Each appears one cycle after its last byte is accepted. s_axis_tready stays 1 throughout.
- Backpressure, part 1: send a word, hold m_axis_tready=0, then send bytes 0x11,0x12,0x13 -> all three accepted. s_axis_tready drops to 0 with cnt=3, and the pending word is held stable.
- Backpressure, part 2: pulse m_axis_tready=1 for one cycle -> first word transfers, byte 0x14 is accepted in the same cycle, and 0x14131211 appears with tvalid still 1.
- Macro on, PACKET_BEATS=2: 16 bytes in -> 4 words; m_axis_tlast=1 on words 2 and 4 only.
- Reset mid-operation: 2 bytes in, arst high for one cycle, then 0xA0..0xA3 -> all outputs reset to 0. The next word is 0xA3A2A1A0, and, with the macro on, beat restarts at 0.
- Random s_axis_tvalid/m_axis_tready (50%), 1000 incrementing bytes, BUS_WIDTH in {1,3,4,8} -> scoreboard sees every byte in order and in correct lanes. tdata/tlast never change while tvalid=1 & tready=0.
